// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: signal bundle between the data-RAM arbiter and its
// surroundings (pipeline MEM stage, host/debug port, RAM macro, counters).
//
// Handshakes:
//   cpu:  cpu_req presents an access for this cycle. It is serviced in the
//         same cycle unless cpu_stall=1, in which case the pipeline is frozen
//         and the identical access must be presented again next cycle.
//   host: host_req is a level request with host_we/addr/wdata held stable.
//         The arbiter answers with a single-cycle host_ack; host_rdata is
//         valid from that cycle until the next ack. The host must drop
//         host_req before a new request is accepted.
//   ram:  ram_* carry one access per cycle; ram_rdata is combinational on
//         ram_addr.
//
// Modports: slave = the arbiter, master = the environment driving it.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [1:0]        cpu_mode;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [31:0]       host_wdata;
  logic              host_ack;
  logic [31:0]       host_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [1:0]        ram_mode;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  logic [15:0]       host_grants;
  logic [31:0]       stall_cycles;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_mode,
    output cpu_rdata, cpu_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata,
    output ram_addr, ram_wdata, ram_mode, ram_we,
    input  ram_rdata,
    output host_grants, stall_cycles
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_mode,
    input  cpu_rdata, cpu_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  ram_addr, ram_wdata, ram_mode, ram_we,
    output ram_rdata,
    input  host_grants, stall_cycles
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-RAM port between the CPU MEM stage and
// a host/debug port. The CPU has priority; the host gets the RAM on an idle
// CPU cycle, or is forced in after MAX_WAIT contended cycles, which costs the
// CPU one stall cycle. Also counts completed host accesses and stall cycles.
//
// Ports:
//   clk          system clock, rising edge
//   clr          asynchronous reset, active-low
//   bus          dmem_arbiter_if.slave: cpu_*, host_*, ram_*, counters
//   dbg_state_o  current arbiter state (0 CPU_OWN, 1 HOST_ACC, 2 HOST_ACK,
//                3 REARM)
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        clr,
  dmem_arbiter_if.slave bus,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    HOST_ACC = 2'd1,
    HOST_ACK = 2'd2,
    REARM    = 2'd3
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] grants_q, grants_d;
  logic [31:0] host_rdata_q, host_rdata_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic              sel_host;
  logic              cpu_stall;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [1:0]        ram_mode;
  logic              ram_we;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q        <= CPU_OWN;
      wait_q         <= '0;
      grants_q       <= '0;
      host_rdata_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      grants_q       <= grants_d;
      host_rdata_q   <= host_rdata_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    grants_d     = grants_q;
    host_rdata_d = host_rdata_q;
    unique case (state_q)
      CPU_OWN: begin
        if (bus.host_req) begin
          // wait_q counts contended cycles already lost; the cycle that sees
          // WAIT_LAST is the last one the CPU may win.
          if (!bus.cpu_req || wait_q == WAIT_LAST) begin
            state_d = HOST_ACC;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end else begin
          wait_d = '0;
        end
      end
      HOST_ACC: begin
        state_d      = HOST_ACK;
        wait_d       = '0;
        grants_d     = grants_q + 16'd1;
        host_rdata_d = bus.ram_rdata;
      end
      HOST_ACK: begin
        state_d = bus.host_req ? REARM : CPU_OWN;
      end
      REARM: begin
        // A still-high request belongs to the access just acknowledged.
        if (!bus.host_req) state_d = CPU_OWN;
      end
      default: state_d = CPU_OWN;
    endcase
  end

  assign sel_host  = (state_q == HOST_ACC);
  assign cpu_stall = sel_host & bus.cpu_req;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (cpu_stall && stall_cycles_q != 32'hFFFF_FFFF)
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_comb begin
    if (sel_host) begin
      ram_addr  = bus.host_addr;
      ram_wdata = bus.host_wdata;
      ram_mode  = 2'b00;
      ram_we    = bus.host_we;
    end else begin
      ram_addr  = bus.cpu_addr;
      ram_wdata = bus.cpu_wdata;
      ram_mode  = bus.cpu_mode;
      ram_we    = bus.cpu_req & bus.cpu_we;
    end
  end

  // clr gates the write strobe directly so a reset landing mid-access never
  // lets a write reach the RAM.
  assign bus.ram_addr     = ram_addr;
  assign bus.ram_wdata    = ram_wdata;
  assign bus.ram_mode     = ram_mode;
  assign bus.ram_we       = ram_we & clr;

  assign bus.cpu_stall    = cpu_stall;
  assign bus.cpu_rdata    = sel_host ? 32'd0 : bus.ram_rdata;
  assign bus.host_ack     = (state_q == HOST_ACK);
  assign bus.host_rdata   = host_rdata_q;
  assign bus.host_grants  = grants_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a word RAM model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dmem_arbiter;
  localparam int ADDR_W   = 12;
  localparam int MAX_WAIT = 8;

  localparam logic [31:0] S_CPU   = 32'd0;
  localparam logic [31:0] S_ACC   = 32'd1;
  localparam logic [31:0] S_ACK   = 32'd2;
  localparam logic [31:0] S_REARM = 32'd3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- RAM model ----------------
  logic [31:0] mem [0:(1<<(ADDR_W-2))-1] = '{default: 32'd0};
  assign bus.ram_rdata = mem[bus.ram_addr[ADDR_W-1:2]];
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr[ADDR_W-1:2]] <= bus.ram_wdata;

  // ---------------- scoreboard ----------------
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic cpu_set(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wd, input logic [1:0] mode);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    bus.cpu_mode  = mode;
  endtask

  task automatic host_set(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wd);
    bus.host_req   = req;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wd;
  endtask

  // Idle-CPU host read whose HOST_ACC cycle collides with a CPU load.
  task automatic stall_grant(input logic [31:0] exp_stalls);
    @(negedge clk);
    cpu_set(1'b0, 1'b0, 12'h050, 32'd0, 2'b00);
    host_set(1'b1, 1'b0, 12'h050, 32'd0);
    @(negedge clk);
    cpu_set(1'b1, 1'b0, 12'h050, 32'd0, 2'b00);
    #1 check_eq("t6_stall", 32'(bus.cpu_stall), 32'd1);
    @(negedge clk);
    host_set(1'b0, 1'b0, 12'h050, 32'd0);
    cpu_set(1'b0, 1'b0, 12'h050, 32'd0, 2'b00);
    #1 check_eq("t6_stall_cnt", bus.stall_cycles, exp_stalls);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- reset: write strobe must be gated even with a store presented ----
    cpu_set(1'b1, 1'b1, 12'h000, 32'h1111_1111, 2'b00);
    host_set(1'b0, 1'b0, 12'h000, 32'd0);
    #1 clr = 1'b0;
    #1;
    check_eq("rst_state",  32'(dbg_state), S_CPU);
    check_eq("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check_eq("rst_ack",    32'(bus.host_ack), 32'd0);
    check_eq("rst_hrdata", bus.host_rdata, 32'd0);
    check_eq("rst_grants", 32'(bus.host_grants), 32'd0);
    check_eq("rst_stalls", bus.stall_cycles, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    cpu_set(1'b0, 1'b0, 12'h000, 32'd0, 2'b00);

    // ---- t1: idle CPU, host write DEADBEEF @0x010 ----
    @(negedge clk);
    host_set(1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF);
    #1 check_eq("t1_req_state", 32'(dbg_state), S_CPU);
    @(negedge clk); #1;
    check_eq("t1_acc_state", 32'(dbg_state), S_ACC);
    check_eq("t1_acc_we",    32'(bus.ram_we), 32'd1);
    check_eq("t1_acc_addr",  32'(bus.ram_addr), 32'h010);
    check_eq("t1_acc_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
    check_eq("t1_acc_stall", 32'(bus.cpu_stall), 32'd0);
    check_eq("t1_acc_ack",   32'(bus.host_ack), 32'd0);
    @(negedge clk); #1;
    check_eq("t1_ack",        32'(bus.host_ack), 32'd1);
    check_eq("t1_ack_we",     32'(bus.ram_we), 32'd0);
    check_eq("t1_grants",     32'(bus.host_grants), 32'd1);
    check_eq("t1_stalls",     bus.stall_cycles, 32'd0);
    host_set(1'b0, 1'b0, 12'h010, 32'd0);
    @(negedge clk); #1;
    check_eq("t1_back_state", 32'(dbg_state), S_CPU);
    check_eq("t1_ack_gone",   32'(bus.host_ack), 32'd0);

    // CPU store of 0x12345678 @0x020 (half-word mode code passes through)
    cpu_set(1'b1, 1'b1, 12'h020, 32'h1234_5678, 2'b10);
    #1;
    check_eq("cpu_st_we",   32'(bus.ram_we), 32'd1);
    check_eq("cpu_st_mode", 32'(bus.ram_mode), 32'd2);

    // ---- t2: continuous CPU loads, host read @0x010 rises together ----
    @(negedge clk);
    cpu_set(1'b1, 1'b0, 12'h020, 32'd0, 2'b10);
    host_set(1'b1, 1'b0, 12'h010, 32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    for (int c = 0; c < MAX_WAIT; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check_eq("t2_wait_state", 32'(dbg_state), S_CPU);
      check_eq("t2_wait_load",  bus.cpu_rdata, 32'h1234_5678);
    end
    @(negedge clk); #1;
    check_eq("t2_acc_state", 32'(dbg_state), S_ACC);
    check_eq("t2_acc_stall", 32'(bus.cpu_stall), 32'd1);
    check_eq("t2_acc_addr",  32'(bus.ram_addr), 32'h010);
    check_eq("t2_acc_rdata", bus.cpu_rdata, 32'd0);
    @(negedge clk); #1;
    check_eq("t2_ack",       32'(bus.host_ack), 32'd1);
    check_eq("t2_hrdata",    bus.host_rdata, exp_q.pop_front());
    check_eq("t2_stalls",    bus.stall_cycles, 32'd1);
    check_eq("t2_grants",    32'(bus.host_grants), 32'd2);
    check_eq("t2_ack_stall", 32'(bus.cpu_stall), 32'd0);

    // ---- t3: host keeps req high after ack ----
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check_eq("t3_rearm_state", 32'(dbg_state), S_REARM);
      check_eq("t3_rearm_ack",   32'(bus.host_ack), 32'd0);
    end
    check_eq("t3_grants", 32'(bus.host_grants), 32'd2);
    host_set(1'b0, 1'b0, 12'h010, 32'd0);
    @(negedge clk); #1;
    check_eq("t3_back_state", 32'(dbg_state), S_CPU);
    check_eq("t3_hrdata_held", bus.host_rdata, 32'hDEAD_BEEF);

    // ---- t4: CPU store lands in the host's granted cycle ----
    cpu_set(1'b0, 1'b0, 12'h000, 32'd0, 2'b00);
    host_set(1'b1, 1'b0, 12'h020, 32'd0);
    exp_q.push_back(32'h1234_5678);
    @(negedge clk);
    cpu_set(1'b1, 1'b1, 12'h030, 32'hCAFE_F00D, 2'b10);
    #1;
    check_eq("t4_acc_state", 32'(dbg_state), S_ACC);
    check_eq("t4_acc_stall", 32'(bus.cpu_stall), 32'd1);
    check_eq("t4_acc_we",    32'(bus.ram_we), 32'd0);
    check_eq("t4_acc_addr",  32'(bus.ram_addr), 32'h020);
    check_eq("t4_acc_mode",  32'(bus.ram_mode), 32'd0);
    @(negedge clk); #1;
    check_eq("t4_retry_we",    32'(bus.ram_we), 32'd1);
    check_eq("t4_retry_addr",  32'(bus.ram_addr), 32'h030);
    check_eq("t4_retry_wdata", bus.ram_wdata, 32'hCAFE_F00D);
    check_eq("t4_retry_mode",  32'(bus.ram_mode), 32'd2);
    check_eq("t4_retry_stall", 32'(bus.cpu_stall), 32'd0);
    check_eq("t4_ack",         32'(bus.host_ack), 32'd1);
    check_eq("t4_hrdata",      bus.host_rdata, exp_q.pop_front());
    check_eq("t4_stalls",      bus.stall_cycles, 32'd2);
    host_set(1'b0, 1'b0, 12'h020, 32'd0);
    @(negedge clk);
    cpu_set(1'b1, 1'b0, 12'h030, 32'd0, 2'b10);
    #1 check_eq("t4_store_data", bus.cpu_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    cpu_set(1'b1, 1'b0, 12'h020, 32'd0, 2'b10);
    #1 check_eq("t4_no_corrupt", bus.cpu_rdata, 32'h1234_5678);
    check_eq("t4_grants", 32'(bus.host_grants), 32'd3);

    // ---- t5: reset pulled during HOST_ACC of a host write ----
    @(negedge clk);
    cpu_set(1'b0, 1'b0, 12'h000, 32'd0, 2'b00);
    host_set(1'b1, 1'b1, 12'h040, 32'h55AA_55AA);
    @(negedge clk); #1;
    check_eq("t5_acc_state", 32'(dbg_state), S_ACC);
    clr = 1'b0;
    #1;
    check_eq("t5_rst_we",     32'(bus.ram_we), 32'd0);
    check_eq("t5_rst_state",  32'(dbg_state), S_CPU);
    check_eq("t5_rst_grants", 32'(bus.host_grants), 32'd0);
    check_eq("t5_rst_stalls", bus.stall_cycles, 32'd0);
    check_eq("t5_rst_ack",    32'(bus.host_ack), 32'd0);
    host_set(1'b0, 1'b0, 12'h040, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    cpu_set(1'b1, 1'b0, 12'h040, 32'd0, 2'b00);
    #1;
    check_eq("t5_no_write", bus.cpu_rdata, 32'd0);
    check_eq("t5_own",      32'(dbg_state), S_CPU);
    check_eq("t5_ack_low",  32'(bus.host_ack), 32'd0);
    @(negedge clk);
    cpu_set(1'b1, 1'b1, 12'h040, 32'h0BAD_F00D, 2'b00);
    #1;
    check_eq("t5_cpu_we",   32'(bus.ram_we), 32'd1);
    check_eq("t5_cpu_addr", 32'(bus.ram_addr), 32'h040);
    check_eq("t5_ack_low2", 32'(bus.host_ack), 32'd0);

    // ---- t6: stall counter saturation ----
    @(negedge clk);
    cpu_set(1'b0, 1'b0, 12'h000, 32'd0, 2'b00);
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cycles_q;
    check_eq("t6_preload", bus.stall_cycles, 32'hFFFF_FFFE);
    stall_grant(32'hFFFF_FFFF);
    stall_grant(32'hFFFF_FFFF);
    check_eq("t6_grants", 32'(bus.host_grants), 32'd2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
